// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared definitions for the sequential restoring divider:
//             default operand widths, FSM state encoding and the quotient
//             value reported for a divide-by-zero.
//  Revision : 1.0  initial release
// ============================================================================
package div_pkg;

    // Default dividend/quotient and divisor/remainder widths.
    localparam int unsigned DIV_N_W = 16;
    localparam int unsigned DIV_D_W = 8;

    // Divider FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Quotient reported when the divisor is zero (all ones).
    localparam logic [DIV_N_W-1:0] DIV_DBZ_QUOTIENT = '1;

endpackage : div_pkg
`default_nettype wire

// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider_if
//  Purpose  : Operand / result handshake bundle of the restoring divider.
//  Ports    : in_valid/in_ready   operand handshake (dividend, divisor)
//             out_valid/out_ready result handshake (quotient, remainder,
//                                 div_by_zero)
//             modport master : operand source and result consumer
//             modport slave  : the divider itself
//  Revision : 1.0  initial release
// ============================================================================
interface seq_restoring_divider_if
    import div_pkg::*;
#(
    parameter int unsigned N_W = DIV_N_W,
    parameter int unsigned D_W = DIV_D_W
);
    logic           in_valid;
    logic           in_ready;
    logic [N_W-1:0] dividend;
    logic [D_W-1:0] divisor;
    logic           out_valid;
    logic           out_ready;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;
    logic           div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface : seq_restoring_divider_if
`default_nettype wire

// File: rtl/seq_restoring_divider_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational restoring-division step. Shifts the next
//             dividend bit into the partial remainder, trial-subtracts the
//             divisor and keeps the difference when it is non-negative.
//  Ports    : i_partial  partial remainder in (D_W+1 bits)
//             i_bit      next dividend bit (MSB first)
//             i_divisor  divisor
//             o_partial  partial remainder out
//             o_qbit     quotient bit produced by this step
//  Revision : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int unsigned D_W = 8
) (
    input  wire logic [D_W:0]   i_partial,
    input  wire logic           i_bit,
    input  wire logic [D_W-1:0] i_divisor,
    output logic      [D_W:0]   o_partial,
    output logic                o_qbit
);

    // One guard bit above the shifted partial so the sign of the trial
    // difference is never lost, whatever the incoming partial holds.
    logic [D_W+1:0] w_shifted;
    logic [D_W+1:0] w_trial;

    always_comb begin
        w_shifted = {i_partial, i_bit};
        w_trial   = w_shifted - {2'b00, i_divisor};
        o_qbit    = ~w_trial[D_W+1];
        o_partial = o_qbit ? w_trial[D_W:0] : w_shifted[D_W:0];
    end

endmodule : div_step
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider
//  Purpose  : Sequential unsigned restoring divider, one quotient bit per
//             clock. A divisor of zero skips the iteration and reports an
//             all-ones quotient, the low dividend bits as remainder and
//             div_by_zero.
//  Ports    : clk    rising-edge clock
//             rst_n  asynchronous active-low reset
//             bus    seq_restoring_divider_if.slave (operand/result
//                    valid-ready handshakes)
//  Revision : 1.0  initial release
// ============================================================================
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned N_W = DIV_N_W,
    parameter int unsigned D_W = DIV_D_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    seq_restoring_divider_if.slave bus
);

    localparam int unsigned          c_CNT_W    = $clog2(N_W);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(N_W - 1);

    div_state_t         r_state;
    div_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_count;
    logic [N_W-1:0]     r_shift;      // dividend bits out, quotient bits in
    logic [D_W:0]       r_partial;
    logic [D_W-1:0]     r_divisor;
    logic [N_W-1:0]     r_quotient;
    logic [D_W-1:0]     r_remainder;
    logic               r_dbz;

    logic               w_accept;
    logic               w_div_zero;
    logic [D_W:0]       w_partial_nxt;
    logic               w_qbit;

    assign w_accept   = (r_state == IDLE) && bus.in_valid;
    assign w_div_zero = (bus.divisor == '0);

    div_step #(
        .D_W (D_W)
    ) u_step (
        .i_partial (r_partial),
        .i_bit     (r_shift[N_W-1]),
        .i_divisor (r_divisor),
        .o_partial (w_partial_nxt),
        .o_qbit    (w_qbit)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_count == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        bus.in_ready    = (r_state == IDLE);
        bus.out_valid   = (r_state == DONE);
        bus.quotient    = r_quotient;
        bus.remainder   = r_remainder;
        bus.div_by_zero = r_dbz;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_shift     <= '0;
            r_partial   <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift   <= bus.dividend;
                r_divisor <= bus.divisor;
                r_partial <= '0;
                if (w_div_zero) begin
                    r_quotient  <= DIV_DBZ_QUOTIENT;
                    r_remainder <= bus.dividend[D_W-1:0];
                    r_dbz       <= 1'b1;
                end else begin
                    r_count <= c_CNT_LAST;
                end
            end else if (r_state == CALC) begin
                r_partial <= w_partial_nxt;
                r_shift   <= {r_shift[N_W-2:0], w_qbit};
                if (r_count == '0) begin
                    // Publish the result on the same edge that enters DONE,
                    // so the visible outputs only ever change to a whole
                    // finished result.
                    r_quotient  <= {r_shift[N_W-2:0], w_qbit};
                    r_remainder <= w_partial_nxt[D_W-1:0];
                    r_dbz       <= 1'b0;
                end else begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

endmodule : seq_restoring_divider
`default_nettype wire
